// File: rtl/mult_div_unit_execute.sv
// Purpose: iterative radix-2 MULT/MULTU/DIV/DIVU unit producing HI/LO for the EXECUTE stage.
// Latency: start sampled at E0, HI/LO update and done pulse at E(WIDTH+1); busy covers RUN and FIX.
// Backpressure: start is ignored while busy; flush aborts silently; HI/LO change only on the FIX edge.
module mult_div_unit_execute #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_execute,
    input  logic [1:0]       op_execute,
    input  logic             flush_execute,
    input  logic [WIDTH-1:0] src_A_ALU_execute,
    input  logic [WIDTH-1:0] src_B_ALU_execute,
    output logic             busy_execute,
    output logic             done_execute,
    output logic [WIDTH-1:0] HI_output_execute,
    output logic [WIDTH-1:0] LO_output_execute
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Control strobes decoded from the FSM
    logic load;
    logic step;
    logic fix;

    // Latched operation context
    logic             is_div;
    logic             sign_a;
    logic             sign_b;
    logic             div_zero;
    logic [WIDTH-1:0] raw_a;
    logic [WIDTH-1:0] mag_a;     // multiplicand, or dividend shifted out MSB-first
    logic [WIDTH-1:0] mag_b;     // multiplier shifted out MSB-first, or divisor
    logic [2*WIDTH-1:0] acc;     // product, or {remainder, quotient}
    logic [CW-1:0]    cnt;

    // Operand magnitudes at start: abs value only for signed ops
    logic             in_sign_a;
    logic             in_sign_b;
    logic [WIDTH-1:0] in_mag_a;
    logic [WIDTH-1:0] in_mag_b;

    // One-step datapath results
    logic [2*WIDTH-1:0] mul_acc_nxt;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     rem_diff;
    logic [2*WIDTH-1:0] div_acc_nxt;

    // Sign-corrected results applied on the FIX edge
    logic               neg_res;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   hi_fix;
    logic [WIDTH-1:0]   lo_fix;

    assign busy_execute = (state != S_IDLE);

    // State register; reset dominates start and flush
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control strobes; flush in IDLE also blocks a start
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        fix       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_execute && !flush_execute) begin
                    load      = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (flush_execute) begin
                    state_nxt = S_IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt == LAST_STEP) begin
                        state_nxt = S_FIX;
                    end
                end
            end
            S_FIX: begin
                state_nxt = S_IDLE;
                fix       = !flush_execute;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand conditioning: unsigned ops pass raw values with cleared sign flags
    always_comb begin
        in_sign_a = op_execute[0] & src_A_ALU_execute[WIDTH-1];
        in_sign_b = op_execute[0] & src_B_ALU_execute[WIDTH-1];
        in_mag_a  = in_sign_a ? (~src_A_ALU_execute + 1'b1) : src_A_ALU_execute;
        in_mag_b  = in_sign_b ? (~src_B_ALU_execute + 1'b1) : src_B_ALU_execute;
    end

    // Single radix-2 step for shift-add multiply and restoring divide
    always_comb begin
        mul_acc_nxt = {acc[2*WIDTH-2:0], 1'b0}
                    + (mag_b[WIDTH-1] ? {{WIDTH{1'b0}}, mag_a} : {(2*WIDTH){1'b0}});
        rem_shift   = {acc[2*WIDTH-1:WIDTH], mag_a[WIDTH-1]};
        rem_diff    = rem_shift - {1'b0, mag_b};
        if (rem_diff[WIDTH]) begin
            div_acc_nxt = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            div_acc_nxt = {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end
    end

    // Sign correction; divide-by-zero returns the raw dividend and all-ones quotient
    always_comb begin
        neg_res  = sign_a ^ sign_b;
        prod_fix = neg_res ? (~acc + 1'b1) : acc;
        quo_fix  = neg_res ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
        rem_fix  = sign_a ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
        hi_fix   = prod_fix[2*WIDTH-1:WIDTH];
        lo_fix   = prod_fix[WIDTH-1:0];
        if (is_div) begin
            if (div_zero) begin
                hi_fix = raw_a;
                lo_fix = {WIDTH{1'b1}};
            end else begin
                hi_fix = rem_fix;
                lo_fix = quo_fix;
            end
        end
    end

    // Datapath: latch on start, iterate in RUN, publish HI/LO and done on FIX
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            is_div            <= 1'b0;
            sign_a            <= 1'b0;
            sign_b            <= 1'b0;
            div_zero          <= 1'b0;
            raw_a             <= '0;
            mag_a             <= '0;
            mag_b             <= '0;
            acc               <= '0;
            cnt               <= '0;
            done_execute      <= 1'b0;
            HI_output_execute <= '0;
            LO_output_execute <= '0;
        end else begin
            if (load) begin
                is_div   <= op_execute[1];
                sign_a   <= in_sign_a;
                sign_b   <= in_sign_b;
                div_zero <= (src_B_ALU_execute == '0);
                raw_a    <= src_A_ALU_execute;
                mag_a    <= in_mag_a;
                mag_b    <= in_mag_b;
                acc      <= '0;
                cnt      <= '0;
            end else if (step) begin
                cnt <= cnt + CW'(1);
                if (is_div) begin
                    acc   <= div_acc_nxt;
                    mag_a <= {mag_a[WIDTH-2:0], 1'b0};
                end else begin
                    acc   <= mul_acc_nxt;
                    mag_b <= {mag_b[WIDTH-2:0], 1'b0};
                end
            end
            if (fix) begin
                HI_output_execute <= hi_fix;
                LO_output_execute <= lo_fix;
            end
            done_execute <= fix;
        end
    end

endmodule

// File: tb/tb_mult_div_unit_execute.sv
// Purpose: directed table-driven check of mult_div_unit_execute plus abort/ignore sequences.
// Latency: expects HI/LO and done exactly 33 edges after the start edge.
// Backpressure: exercises start-while-busy, flush in RUN/FIX/IDLE and reset mid-operation.
module tb_mult_div_unit_execute;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic        flush;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[14];

    mult_div_unit_execute #(.WIDTH(32)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start_execute     (start),
        .op_execute        (op),
        .flush_execute     (flush),
        .src_A_ALU_execute (src_a),
        .src_B_ALU_execute (src_b),
        .busy_execute      (busy),
        .done_execute      (done),
        .HI_output_execute (hi),
        .LO_output_execute (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Issue one op and wait for done; optionally pulse a second start at E5
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input bit poke);
        int n;
        bit overlap;
        overlap = 1'b0;
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        chk({tag, " busy_after_start"}, busy, 1);
        while (!done && n < 100) begin
            if (poke && n == 4) begin
                start = 1'b1; op = OP_MULTU; src_a = 32'h5; src_b = 32'h9;
            end else if (poke && n == 5) begin
                start = 1'b0;
            end
            if (busy && done) overlap = 1'b1;
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, n, 33);
        chk({tag, " busy_with_done"}, {busy, overlap}, 0);
        chk({tag, " hi"}, hi, exp_hi);
        chk({tag, " lo"}, lo, exp_lo);
        @(negedge clk);
        chk({tag, " done_one_cycle"}, {busy, done}, 0);
        chk({tag, " lo_hold"}, lo, exp_lo);
    endtask

    initial begin
        bit saw_done;

        vecs[0]  = '{"multu_max",   OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{"mult_neg3x5", OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2]  = '{"div_m7_2",    OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{"div_ovf",     OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[4]  = '{"divu_by0",    OP_DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
        vecs[5]  = '{"div_by0",     OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[6]  = '{"mult_7xm2",   OP_MULT,  32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2};
        vecs[7]  = '{"div_7_m2",    OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[8]  = '{"mult_min_sq", OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[9]  = '{"divu_max_1",  OP_DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
        vecs[10] = '{"mult_min_m1", OP_MULT,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[11] = '{"div_m7_m2",   OP_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003};
        vecs[12] = '{"multu_big",   OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
        vecs[13] = '{"divu_1000_3", OP_DIVU,  32'h000003E8, 32'h00000003, 32'h00000001, 32'h0000014D};

        // Reset, with start held high to show reset dominates
        reset_n = 1'b0; start = 1'b1; flush = 1'b0; op = OP_MULTU;
        src_a = 32'h3; src_b = 32'h4;
        repeat (3) @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset hi", hi, 0);
        chk("reset lo", lo, 0);
        start = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle after reset", busy, 0);

        foreach (vecs[i]) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].exp_hi, vecs[i].exp_lo, 1'b0);
        end

        // Start pulsed while busy is ignored
        run_op("divu_ignore_restart", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);

        // Flush during RUN
        run_op("multu_3x4", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);
        @(negedge clk);
        start = 1'b1; op = OP_MULTU; src_a = 32'd5; src_b = 32'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_run busy", busy, 0);
        chk("flush_run done", done, 0);
        chk("flush_run hi", hi, 0);
        chk("flush_run lo", lo, 12);
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        chk("flush_run no_late_done", saw_done, 0);
        chk("flush_run lo_hold", lo, 12);

        // Flush on the FIX edge suppresses the result
        @(negedge clk);
        start = 1'b1; op = OP_MULTU; src_a = 32'd5; src_b = 32'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (32) @(negedge clk);
        chk("flush_fix busy_before", busy, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_fix busy", busy, 0);
        chk("flush_fix done", done, 0);
        chk("flush_fix lo", lo, 12);

        // Flush in IDLE blocks a simultaneous start
        start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush_idle busy", busy, 0);

        // Reset mid-operation clears HI/LO
        @(negedge clk);
        start = 1'b1; op = OP_MULTU; src_a = 32'd5; src_b = 32'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("reset_mid busy", busy, 0);
        chk("reset_mid done", done, 0);
        chk("reset_mid hi", hi, 0);
        chk("reset_mid lo", lo, 0);

        // Recovery after the abort
        run_op("multu_5x6", OP_MULTU, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
